// File: rtl/rast_hit_merge.sv
// rast_hit_merge: packs up to LANES hits per cycle into a show-ahead FIFO and drains it over one valid/ready stream.
// Define RAST_HIT_STATS_EN to add the saturating hit/drop counters.
module rast_hit_merge #(
  parameter int SIGFIG      = 24,
  parameter int AXIS        = 3,
  parameter int COLORS      = 3,
  parameter int LANES       = 2,
  parameter int DEPTH       = 16,
  parameter int HALT_THRESH = 8
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [LANES-1:0]                           hit_valid_R18H,
  input  logic [LANES-1:0][AXIS-1:0][SIGFIG-1:0]     hit_R18S,
  input  logic [LANES-1:0][COLORS-1:0][SIGFIG-1:0]   color_R18U,
  output logic                                       halt_RnnnnL,
  output logic                                       out_valid_R19H,
  input  logic                                       out_ready_R19H,
  output logic [AXIS-1:0][SIGFIG-1:0]                out_hit_R19S,
  output logic [COLORS-1:0][SIGFIG-1:0]              out_color_R19U,
  output logic                                       overflow_RnnnnH
`ifdef RAST_HIT_STATS_EN
  ,
  output logic [31:0]                                hit_count_RnnnnU,
  output logic [15:0]                                drop_count_RnnnnU
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = (AXIS + COLORS) * SIGFIG;
  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d, free, n, nd;
  logic halt_q, ovf_q, pop;
  logic [LANES-1:0] we;
  logic [LANES-1:0][PW-1:0] wa;
  // Free space is taken before this cycle's pop; lanes beyond it are dropped.
  always_comb begin
    free = CW'(DEPTH) - cnt_q;
    pop = (cnt_q != '0) && out_ready_R19H;
    n = '0;
    nd = '0;
    we = '0;
    wa = '0;
    for (int l = 0; l < LANES; l++) begin
      wa[l] = wr_q + n[PW-1:0];
      we[l] = hit_valid_R18H[l] && (n < free);
      nd = nd + CW'(hit_valid_R18H[l] && !we[l]);
      n = n + CW'(we[l]);
    end
    wr_d = wr_q + n[PW-1:0];
    rd_d = rd_q + PW'(pop);
    cnt_d = cnt_q + n - CW'(pop);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      halt_q <= 1'b1;
      ovf_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      halt_q <= !((CW'(DEPTH) - cnt_d) < CW'(HALT_THRESH));
      ovf_q <= ovf_q | (nd != '0);
    end
  always_ff @(posedge clk)
    for (int l = 0; l < LANES; l++)
      if (we[l]) mem_q[wa[l]] <= {hit_R18S[l], color_R18U[l]};
  assign out_valid_R19H = cnt_q != '0;
  assign {out_hit_R19S, out_color_R19U} = mem_q[rd_q];
  assign halt_RnnnnL = halt_q;
  assign overflow_RnnnnH = ovf_q;
`ifdef RAST_HIT_STATS_EN
  logic [31:0] hits_q;
  logic [15:0] drops_q;
  logic [32:0] hits_sum;
  logic [16:0] drops_sum;
  always_comb begin
    hits_sum = {1'b0, hits_q} + 33'(n);
    drops_sum = {1'b0, drops_q} + 17'(nd);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hits_q <= '0;
      drops_q <= '0;
    end else begin
      hits_q <= hits_sum[32] ? '1 : hits_sum[31:0];
      drops_q <= drops_sum[16] ? '1 : drops_sum[15:0];
    end
  assign hit_count_RnnnnU = hits_q;
  assign drop_count_RnnnnU = drops_q;
`endif
endmodule

// File: tb/tb_rast_hit_merge.sv
// tb_rast_hit_merge: directed and randomized checks of rast_hit_merge against a queue-based FIFO model.
module tb_rast_hit_merge;
  localparam int DEPTH = 16;
  localparam int THRESH = 8;
  logic clk = 0, rst = 0;
  logic [1:0] hv;
  logic [1:0][2:0][23:0] hit, col;
  logic halt, ov, rdy, ovf;
  logic [2:0][23:0] oh, oc;
  logic [143:0] q[$];
  logic halt_m, ovf_m;
  longint hits_m, drops_m;
  int errors = 0, checks = 0;
`ifdef RAST_HIT_STATS_EN
  logic [31:0] hc;
  logic [15:0] dc;
`endif
  rast_hit_merge dut (
    .clk(clk), .rst(rst), .hit_valid_R18H(hv), .hit_R18S(hit), .color_R18U(col),
    .halt_RnnnnL(halt), .out_valid_R19H(ov), .out_ready_R19H(rdy),
    .out_hit_R19S(oh), .out_color_R19U(oc), .overflow_RnnnnH(ovf)
`ifdef RAST_HIT_STATS_EN
    , .hit_count_RnnnnU(hc), .drop_count_RnnnnU(dc)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    q.delete();
    halt_m = 1;
    ovf_m = 0;
    hits_m = 0;
    drops_m = 0;
  endtask
  task automatic check_outputs();
    chk("out_valid", 144'(ov), 144'(q.size() != 0));
    if (q.size() != 0) chk("head", {oh, oc}, q[0]);
    chk("halt", 144'(halt), 144'(halt_m));
    chk("overflow", 144'(ovf), 144'(ovf_m));
`ifdef RAST_HIT_STATS_EN
    chk("hit_count", 144'(hc), 144'(hits_m));
    chk("drop_count", 144'(dc), 144'(drops_m));
`endif
  endtask
  task automatic rnd_data();
    for (int l = 0; l < 2; l++)
      for (int a = 0; a < 3; a++) begin
        hit[l][a] = 24'($urandom);
        col[l][a] = 24'($urandom);
      end
  endtask
  // Checks current outputs, applies v/r for one clock, advances the model.
  task automatic cyc(input logic [1:0] v, input logic r);
    int free, nw;
    hv = v;
    rdy = r;
    check_outputs();
    free = DEPTH - q.size();
    nw = 0;
    if (q.size() != 0 && r) void'(q.pop_front());
    for (int l = 0; l < 2; l++)
      if (v[l]) begin
        if (nw < free) begin
          q.push_back({hit[l], col[l]});
          nw++;
        end else begin
          ovf_m = 1;
          drops_m++;
        end
      end
    hits_m += nw;
    halt_m = !((DEPTH - q.size()) < THRESH);
    @(posedge clk);
    #1;
    rnd_data();
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) cyc(2'b00, 1);
    cyc(2'b00, 1);
  endtask
  initial begin
    hv = 0;
    rdy = 0;
    rnd_data();
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1;
    // single hit on lane 0, visible the next cycle then gone
    hit[0][0] = 24'd5;
    hit[0][1] = 24'd7;
    hit[0][2] = 24'd1;
    cyc(2'b01, 1);
    chk("x", 144'(oh[0]), 144'd5);
    chk("y", 144'(oh[1]), 144'd7);
    chk("z", 144'(oh[2]), 144'd1);
    cyc(2'b00, 1);
    cyc(2'b00, 1);
    // three double-lane cycles, no drain, then order check
    repeat (3) cyc(2'b11, 0);
    cyc(2'b00, 0);
    drain();
    // fill to 9: halt drops, drain 2: halt returns
    repeat (4) cyc(2'b11, 0);
    cyc(2'b01, 0);
    cyc(2'b00, 0);
    chk("halt_at_9", 144'(halt), 144'd0);
    repeat (2) cyc(2'b00, 1);
    cyc(2'b00, 0);
    chk("halt_at_7", 144'(halt), 144'd1);
    drain();
    // fill to 15, both lanes with pop: lane 1 dropped
    repeat (7) cyc(2'b11, 0);
    cyc(2'b01, 0);
    cyc(2'b11, 1);
    cyc(2'b00, 0);
    chk("overflow_set", 144'(ovf), 144'd1);
    chk("count15", 144'(q.size()), 144'd15);
    drain();
    // 40 hits streamed through, wraps pointers
    for (int i = 0; i < 40; i++) cyc($urandom_range(0, 1) ? 2'b01 : 2'b10, 1);
    drain();
    // async reset with 5 entries held
    repeat (2) cyc(2'b11, 0);
    cyc(2'b01, 0);
    #2 rst = 0;
    #1;
    chk("rst_valid", 144'(ov), 144'd0);
    chk("rst_halt", 144'(halt), 144'd1);
    chk("rst_ovf", 144'(ovf), 144'd0);
`ifdef RAST_HIT_STATS_EN
    chk("rst_hits", 144'(hc), 144'd0);
    chk("rst_drops", 144'(dc), 144'd0);
`endif
    model_reset();
    #1 rst = 1;
    // fully random traffic, overflow allowed
    for (int i = 0; i < 60; i++) cyc(2'($urandom), 1'($urandom));
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
